wb_synapse_loader: RTL and testbench
====================================

WB_SYNAPSE_LOADER -- requirements
Module: wb_synapse_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles waiting for wbm_ack_i per bus cycle (range 1..255).
REQ-002 SHALL have one clock and asynchronous active-high reset, named as below:
- wb_clk_i  in  1  clock; all state changes on the rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have the command ports:
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_we_i  in  1  1 = write burst, 0 = read burst.
- cmd_addr_i  in  32  byte start address; bits [1:0] ignored and treated as 0.
- cmd_len_i  in  8  word count; 0 = no bus cycles.
REQ-004 SHALL have the data stream ports:
- wr_data_i  in  32  write word.
- wr_valid_i  in  1  write word offered.
- wr_ready_o  out  1  write word taken when high together with wr_valid_i.
- rd_data_o  out  32  read word.
- rd_valid_o  out  1  read word offered.
- rd_ready_i  in  1  read word consumed when high together with rd_valid_o.
REQ-005 SHALL have the Wishbone classic master ports:
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each.
- wbm_sel_o  out  4.
- wbm_adr_o  out  32.
- wbm_dat_o  out  32.
- wbm_dat_i  in  32.
- wbm_ack_i  in  1.
REQ-006 SHALL have the status ports:
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when a burst completes.
- err_o  out  1  one-cycle pulse when a burst times out.

Function
REQ-007 SHALL implement FSM states IDLE, FETCH, BUS, RDOUT, DONE; all outputs registered.
REQ-008 SHALL assert cmd_ready_o only in IDLE; on acceptance it latches we, the word-aligned address and len into a remaining-count register.
REQ-009 SHALL move from IDLE, on an accepted command, to DONE if len=0, to FETCH if we=1, or to BUS if we=0.
REQ-010 SHALL assert wr_ready_o only in FETCH; on handshake it latches wr_data_i into wbm_dat_o and enters BUS the next cycle.
REQ-011 SHALL, in BUS, hold wbm_cyc_o=wbm_stb_o=1, wbm_sel_o=4'hF, wbm_we_o=latched we, and wbm_adr_o and wbm_dat_o stable until ack or timeout.
REQ-012 SHALL, for a read, assert cyc/stb in the cycle after command acceptance (1-cycle latency).
REQ-013 SHALL, for a write, assert cyc/stb in the cycle after the wr handshake.
REQ-014 SHALL, on the edge sampling wbm_ack_i=1 in BUS:
- deassert cyc/stb the next cycle;
- decrement the remaining count;
- add 4 to the address (32-bit wrap: 0xFFFFFFFC -> 0x00000000).
REQ-015 SHALL, on a read ack, capture wbm_dat_i into rd_data_o, assert rd_valid_o and enter RDOUT.
REQ-016 SHALL hold rd_valid_o and rd_data_o in RDOUT until rd_ready_i=1; on that edge it clears rd_valid_o.
REQ-017 SHALL, after each word's completion (write ack, or read rd_ready_i handshake), go to FETCH (write) or BUS (read) if words remain, else to DONE.
REQ-018 SHALL pulse done_o for exactly one cycle in DONE, then return to IDLE.
REQ-019 SHALL keep a timeout counter, cleared on entry to BUS and incremented each BUS cycle without ack.
REQ-020 SHALL, when the timeout counter reaches TIMEOUT_CYCLES without ack:
- deassert cyc/stb;
- pulse err_o for one cycle;
- abandon the remaining words;
- return to IDLE without a done_o pulse.
REQ-021 SHALL ignore wbm_ack_i outside BUS; an ack in the same cycle as the timeout count being reached wins (word completes, no err_o).
REQ-022 SHALL ignore cmd_valid_i while busy_o=1; no command queuing.

Reset
REQ-023 SHALL, while wb_rst_i=1, immediately force:
- IDLE;
- cyc/stb/we = 0;
- sel/adr/dat_o = 0;
- rd_data_o = 0;
- rd_valid_o, wr_ready_o, done_o, err_o, busy_o = 0;
- counters = 0.
It also forces cmd_ready_o = 0.
REQ-024 SHALL assert cmd_ready_o=1 in the first cycle after reset release; a burst interrupted by reset is discarded.

Verification
REQ-025 Write burst: addr 0x3000_0010, len 3, words A,B,C, ack 1 cycle after stb -> three cycles at adr 0x3000_0010/14/18 with dat A,B,C, we=1, sel=F; then one done_o pulse.
REQ-026 Read burst: addr 0x3000_0000, len 2, slave returns 0x11, 0x22, rd_ready_i held low 3 cycles -> rd_valid_o held with 0x11 stable; no second bus cycle until the handshake; then 0x22, then done_o.
REQ-027 Timeout: TIMEOUT_CYCLES=4, no ack, len 2 -> stb high exactly 4 cycles, one err_o pulse, no done_o, only one bus cycle issued, cmd_ready_o=1 afterwards.
REQ-028 len=0 and address wrap:
- len=0 command -> no cyc, done_o one cycle after acceptance.
- addr 0xFFFF_FFFC, len 2 -> adr 0xFFFF_FFFC then 0x0000_0000.
REQ-029 Reset mid-BUS: assert wb_rst_i while stb=1 -> cyc/stb drop without waiting for an edge; after release cmd_ready_o=1 and a new read burst completes normally.

Source files
------------

// File: rtl/wb_synapse_loader_if.sv
// Signal bundle for wb_synapse_loader: command port, write/read word streams,
// Wishbone classic master bus and status pulses.
interface wb_synapse_loader_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_addr_i;
    logic [7:0]  cmd_len_i;

    logic [31:0] wr_data_i;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        rd_ready_i;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    logic        busy_o;
    logic        done_o;
    logic        err_o;

    // Loader side: drives the Wishbone bus and the handshake outputs.
    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_len_i,
        input  wr_data_i, wr_valid_i, rd_ready_i,
        input  wbm_dat_i, wbm_ack_i,
        output cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output busy_o, done_o, err_o
    );

    // Environment side: command source, stream endpoints and Wishbone slave.
    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_len_i,
        output wr_data_i, wr_valid_i, rd_ready_i,
        output wbm_dat_i, wbm_ack_i,
        input  cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  busy_o, done_o, err_o
    );
endinterface

// File: rtl/wb_synapse_loader.sv
// Burst loader: turns a (we, addr, len) command into consecutive single-word
// Wishbone classic cycles, fed from / drained to valid-ready word streams.
module wb_synapse_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    wb_synapse_loader_if.master        bus_io
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StBus,
        StRdout,
        StDone
    } state_e;

    // Last counter value before the limit; an unacked cycle here times out.
    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  rem_q, rem_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        wr_ready_q, wr_ready_d;
    logic        cyc_q, cyc_d;
    logic        wbm_we_q, wbm_we_d;
    logic [3:0]  sel_q, sel_d;
    logic        busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rem_d      = rem_q;
        tmo_d      = tmo_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus_io.cmd_valid_i && cmd_ready_q) begin
                    we_d  = bus_io.cmd_we_i;
                    adr_d = bus_io.cmd_addr_i & 32'hFFFF_FFFC;
                    rem_d = bus_io.cmd_len_i;
                    if (bus_io.cmd_len_i == 8'd0) begin
                        state_d = StDone;
                    end else if (bus_io.cmd_we_i) begin
                        state_d = StFetch;
                    end else begin
                        state_d = StBus;
                    end
                end
            end
            StFetch: begin
                if (bus_io.wr_valid_i && wr_ready_q) begin
                    dat_d   = bus_io.wr_data_i;
                    state_d = StBus;
                end
            end
            StBus: begin
                // Ack takes priority over a timeout reached in the same cycle.
                if (bus_io.wbm_ack_i) begin
                    rem_d = rem_q - 8'd1;
                    adr_d = adr_q + 32'd4;
                    if (we_q) begin
                        state_d = (rem_q > 8'd1) ? StFetch : StDone;
                    end else begin
                        rd_data_d  = bus_io.wbm_dat_i;
                        rd_valid_d = 1'b1;
                        state_d    = StRdout;
                    end
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    rem_d   = 8'd0;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StRdout: begin
                if (bus_io.rd_ready_i && rd_valid_q) begin
                    rd_valid_d = 1'b0;
                    state_d    = (rem_q != 8'd0) ? StBus : StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d == StBus && state_q != StBus) begin
            tmo_d = 8'd0;
        end

        // Outputs are registered from the next state so they line up with it.
        cmd_ready_d = (state_d == StIdle);
        wr_ready_d  = (state_d == StFetch);
        cyc_d       = (state_d == StBus);
        wbm_we_d    = cyc_d & we_d;
        sel_d       = cyc_d ? 4'hF : 4'h0;
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            adr_q       <= 32'd0;
            dat_q       <= 32'd0;
            rem_q       <= 8'd0;
            tmo_q       <= 8'd0;
            rd_data_q   <= 32'd0;
            rd_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            cyc_q       <= 1'b0;
            wbm_we_q    <= 1'b0;
            sel_q       <= 4'h0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rem_q       <= rem_d;
            tmo_q       <= tmo_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            err_q       <= err_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            cyc_q       <= cyc_d;
            wbm_we_q    <= wbm_we_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
        end
    end

    assign bus_io.cmd_ready_o = cmd_ready_q;
    assign bus_io.wr_ready_o  = wr_ready_q;
    assign bus_io.rd_data_o   = rd_data_q;
    assign bus_io.rd_valid_o  = rd_valid_q;
    assign bus_io.wbm_cyc_o   = cyc_q;
    assign bus_io.wbm_stb_o   = cyc_q;
    assign bus_io.wbm_we_o    = wbm_we_q;
    assign bus_io.wbm_sel_o   = sel_q;
    assign bus_io.wbm_adr_o   = adr_q;
    assign bus_io.wbm_dat_o   = dat_q;
    assign bus_io.busy_o      = busy_q;
    assign bus_io.done_o      = done_q;
    assign bus_io.err_o       = err_q;

endmodule

// File: tb/tb_wb_synapse_loader.sv
// Directed bench for wb_synapse_loader: write/read bursts, read back-pressure,
// timeout, zero-length command, address wrap and reset during a bus cycle.
module tb_wb_synapse_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_synapse_loader_if bus ();

    wb_synapse_loader #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus_io  (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Wishbone slave: ack one cycle after stb; read data encodes adr[4:2].
    logic ack_en = 1'b0;
    always @(posedge clk) begin
        bus.wbm_ack_i <= bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i && ack_en;
        bus.wbm_dat_i <= 32'h11 * ({29'd0, bus.wbm_adr_o[4:2]} + 32'd1);
    end

    // Bus monitor, sampled on the falling edge.
    int          n_xfer = 0;
    int          n_stb  = 0;
    int          n_rise = 0;
    int          n_done = 0;
    int          n_err  = 0;
    logic        prev_stb = 1'b0;
    logic [31:0] x_adr [64];
    logic [31:0] x_dat [64];
    logic        x_we  [64];
    logic [3:0]  x_sel [64];

    always @(negedge clk) begin
        if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
            n_stb <= n_stb + 1;
            if (!prev_stb) n_rise <= n_rise + 1;
            if (bus.wbm_ack_i && n_xfer < 64) begin
                x_adr[n_xfer] <= bus.wbm_adr_o;
                x_dat[n_xfer] <= bus.wbm_dat_o;
                x_we[n_xfer]  <= bus.wbm_we_o;
                x_sel[n_xfer] <= bus.wbm_sel_o;
                n_xfer        <= n_xfer + 1;
            end
        end
        prev_stb <= (bus.wbm_stb_o === 1'b1);
        if (bus.done_o === 1'b1) n_done <= n_done + 1;
        if (bus.err_o === 1'b1) n_err <= n_err + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    int b_x, b_done, b_err, b_rise, b_stb;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic baseline();
        b_x    = n_xfer;
        b_done = n_done;
        b_err  = n_err;
        b_rise = n_rise;
        b_stb  = n_stb;
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [7:0] len);
        int n;
        bus.cmd_we_i    = we;
        bus.cmd_addr_i  = addr;
        bus.cmd_len_i   = len;
        bus.cmd_valid_i = 1'b1;
        n = 0;
        while (bus.cmd_ready_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check1("cmd_ready", bus.cmd_ready_o, 1'b1);
        tick();
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] data);
        int n;
        bus.wr_data_i  = data;
        bus.wr_valid_i = 1'b1;
        n = 0;
        while (bus.wr_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check1("wr_ready", bus.wr_ready_o, 1'b1);
        tick();
        bus.wr_valid_i = 1'b0;
    endtask

    task automatic wait_rd();
        int n;
        n = 0;
        while (bus.rd_valid_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check1("rd_valid_wait", bus.rd_valid_o, 1'b1);
    endtask

    task automatic take_rd();
        bus.rd_ready_i = 1'b1;
        tick();
        bus.rd_ready_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy_o !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check1("idle_wait", bus.busy_o, 1'b0);
        tick();
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_addr_i  = 32'd0;
        bus.cmd_len_i   = 8'd0;
        bus.wr_data_i   = 32'd0;
        bus.wr_valid_i  = 1'b0;
        bus.rd_ready_i  = 1'b0;

        // Reset state
        tick();
        tick();
        check1("rst_cyc", bus.wbm_cyc_o, 1'b0);
        check1("rst_stb", bus.wbm_stb_o, 1'b0);
        check1("rst_we", bus.wbm_we_o, 1'b0);
        check32("rst_sel", 32'(bus.wbm_sel_o), 32'h0);
        check32("rst_adr", bus.wbm_adr_o, 32'h0);
        check32("rst_dat", bus.wbm_dat_o, 32'h0);
        check32("rst_rd_data", bus.rd_data_o, 32'h0);
        check1("rst_rd_valid", bus.rd_valid_o, 1'b0);
        check1("rst_wr_ready", bus.wr_ready_o, 1'b0);
        check1("rst_cmd_ready", bus.cmd_ready_o, 1'b0);
        check1("rst_busy", bus.busy_o, 1'b0);
        check1("rst_done", bus.done_o, 1'b0);
        check1("rst_err", bus.err_o, 1'b0);
        rst = 1'b0;
        tick();
        check1("post_rst_ready", bus.cmd_ready_o, 1'b1);

        // Write burst of three words
        ack_en = 1'b1;
        baseline();
        send_cmd(1'b1, 32'h3000_0010, 8'd3);
        check1("wr_busy", bus.busy_o, 1'b1);
        check1("wr_cmd_ready_low", bus.cmd_ready_o, 1'b0);
        push_word(32'hA5A5_0001);
        push_word(32'h5A5A_0002);
        push_word(32'hDEAD_BEEF);
        wait_idle();
        check32("wr_nxfer", 32'(n_xfer - b_x), 32'd3);
        check32("wr_adr0", x_adr[b_x], 32'h3000_0010);
        check32("wr_adr1", x_adr[b_x + 1], 32'h3000_0014);
        check32("wr_adr2", x_adr[b_x + 2], 32'h3000_0018);
        check32("wr_dat0", x_dat[b_x], 32'hA5A5_0001);
        check32("wr_dat1", x_dat[b_x + 1], 32'h5A5A_0002);
        check32("wr_dat2", x_dat[b_x + 2], 32'hDEAD_BEEF);
        check1("wr_we", x_we[b_x + 1], 1'b1);
        check32("wr_sel", 32'(x_sel[b_x + 2]), 32'hF);
        check32("wr_done", 32'(n_done - b_done), 32'd1);
        check32("wr_err", 32'(n_err - b_err), 32'd0);

        // Read burst with three cycles of back-pressure on the first word
        baseline();
        send_cmd(1'b0, 32'h3000_0000, 8'd2);
        check1("rd_cyc_latency", bus.wbm_cyc_o, 1'b1);
        check1("rd_we", bus.wbm_we_o, 1'b0);
        wait_rd();
        check32("rd_data0", bus.rd_data_o, 32'h11);
        for (int i = 0; i < 3; i++) begin
            tick();
            check1($sformatf("rd_hold_valid%0d", i), bus.rd_valid_o, 1'b1);
            check32($sformatf("rd_hold_data%0d", i), bus.rd_data_o, 32'h11);
            check1($sformatf("rd_hold_stb%0d", i), bus.wbm_stb_o, 1'b0);
        end
        check32("rd_one_xfer", 32'(n_xfer - b_x), 32'd1);
        take_rd();
        check1("rd_valid_clr", bus.rd_valid_o, 1'b0);
        check1("rd_stb2", bus.wbm_stb_o, 1'b1);
        check32("rd_adr2", bus.wbm_adr_o, 32'h3000_0004);
        wait_rd();
        check32("rd_data1", bus.rd_data_o, 32'h22);
        take_rd();
        wait_idle();
        check32("rd_nxfer", 32'(n_xfer - b_x), 32'd2);
        check32("rd_done", 32'(n_done - b_done), 32'd1);

        // Timeout: no ack, TIMEOUT_CYCLES = 4
        ack_en = 1'b0;
        baseline();
        send_cmd(1'b0, 32'h5000_0000, 8'd2);
        wait_idle();
        check32("tmo_stb_cycles", 32'(n_stb - b_stb), 32'd4);
        check32("tmo_bus_cycles", 32'(n_rise - b_rise), 32'd1);
        check32("tmo_err", 32'(n_err - b_err), 32'd1);
        check32("tmo_done", 32'(n_done - b_done), 32'd0);
        check1("tmo_err_clr", bus.err_o, 1'b0);
        check1("tmo_cmd_ready", bus.cmd_ready_o, 1'b1);

        // Zero-length command
        ack_en = 1'b1;
        baseline();
        send_cmd(1'b0, 32'h1234_5678, 8'd0);
        check1("len0_done", bus.done_o, 1'b1);
        check1("len0_cyc", bus.wbm_cyc_o, 1'b0);
        tick();
        check1("len0_done_clr", bus.done_o, 1'b0);
        check1("len0_cmd_ready", bus.cmd_ready_o, 1'b1);
        check32("len0_no_bus", 32'(n_rise - b_rise), 32'd0);
        check32("len0_done_cnt", 32'(n_done - b_done), 32'd1);

        // Address wrap; low address bits are dropped
        baseline();
        send_cmd(1'b1, 32'hFFFF_FFFE, 8'd2);
        push_word(32'hCAFE_0001);
        push_word(32'hCAFE_0002);
        wait_idle();
        check32("wrap_adr0", x_adr[b_x], 32'hFFFF_FFFC);
        check32("wrap_adr1", x_adr[b_x + 1], 32'h0000_0000);
        check32("wrap_dat1", x_dat[b_x + 1], 32'hCAFE_0002);
        check32("wrap_done", 32'(n_done - b_done), 32'd1);

        // Reset in the middle of a bus cycle
        ack_en = 1'b0;
        send_cmd(1'b0, 32'h6000_0000, 8'd4);
        tick();
        check1("mid_stb", bus.wbm_stb_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        check1("mid_rst_cyc", bus.wbm_cyc_o, 1'b0);
        check1("mid_rst_stb", bus.wbm_stb_o, 1'b0);
        check1("mid_rst_busy", bus.busy_o, 1'b0);
        check1("mid_rst_cmd_ready", bus.cmd_ready_o, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check1("mid_post_ready", bus.cmd_ready_o, 1'b1);
        ack_en = 1'b1;
        baseline();
        send_cmd(1'b0, 32'h4000_0008, 8'd1);
        wait_rd();
        check32("mid_rd_data", bus.rd_data_o, 32'h33);
        take_rd();
        wait_idle();
        check32("mid_rd_adr", x_adr[b_x], 32'h4000_0008);
        check32("mid_rd_done", 32'(n_done - b_done), 32'd1);
        check32("mid_rd_err", 32'(n_err - b_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
